sis_crdata_avmm_responder: RTL and testbench
============================================

Name: sis_crdata_avmm_responder

Overview:
- Avalon-MM responder (slave) for the 64-bit `avmm_0_rw` master port driven by the SiS CR-data conversion HLS component.
- Backs the `SiS_Pr` / `crdata` table space with on-chip word memory.
- Serves fixed-latency reads and byte-enabled writes, with no `waitrequest` and no `readdatavalid`. This matches the master's fixed-latency expectation.
- Also provides a backdoor preload/peek port so the system or bench can load CR tables and inspect results.

Parameters:
- ADDR_W, 8, log2 of memory depth in 64-bit words (depth = 2^ADDR_W).
- READ_LATENCY, 2, cycles from accepted read to readdata valid; legal range 1..4.
- BASE_ADDR, 64'h0, byte address mapped to word 0.

Ports:
- clock  in  1  single clock domain.
- reset  in  1  asynchronous, active-high reset.
- avmm_0_rw_address  in  64  byte address from master.
- avmm_0_rw_byteenable  in  8  per-byte write enable.
- avmm_0_rw_read  in  1  read request.
- avmm_0_rw_write  in  1  write request.
- avmm_0_rw_writedata  in  64  write data.
- avmm_0_rw_readdata  out  64  read data, valid READ_LATENCY cycles after the read.
- pre_we  in  1  backdoor write strobe.
- pre_addr  in  ADDR_W  backdoor word index.
- pre_wdata  in  64  backdoor write data, full word.
- pre_rdata  out  64  backdoor read data, registered, 1-cycle latency.
- err  out  1  sticky protocol/address error flag.
- err_clr  in  1  clears err.

Behaviour:
- Reset (async assert, sync release):
  - readdata = 0, pre_rdata = 0, err = 0.
  - Read-latency pipeline valid bits cleared.
  - Memory contents are not reset.
- Address decode: off = address − BASE_ADDR; word = off[ADDR_W+2:3].
  - Legal iff off[2:0] == 0 and off[63:ADDR_W+3] == 0.
  - Subtraction is 64-bit modulo; an address below BASE_ADDR wraps and is illegal.
- Write, accepted every cycle:
  - Legal: each byte b with byteenable[b]=1 updates mem[word][8b+7:8b]; other bytes are untouched.
  - byteenable = 0: no update, no error.
  - Illegal: dropped, err set.
- Read, accepted every cycle, fully pipelined:
  - Memory is sampled in the issue cycle (read-before-write: a write to the same word in the same cycle is not visible).
  - Data shifts through a READ_LATENCY-stage pipeline; readdata updates only when the last stage is valid, otherwise it holds its last value.
  - Illegal: pipeline carries 0 and err is set.
- Back-to-back reads return in order, one per cycle.
- read and write asserted together: protocol error. err is set, the write is performed if legal, and the read is served normally.
- Backdoor port:
  - pre_we writes the full word pre_addr.
  - pre_rdata <= mem[pre_addr] every cycle, read-before-write.
  - Same-cycle Avalon write to the same word: pre_we wins entirely. Different words: both writes are performed.
- err is sticky until err_clr. err_clr in the same cycle as a new error leaves err = 1 (set wins).
- Reset mid-operation: in-flight reads are discarded; no readdata update occurs for them after reset release.

Optional Feature:
- Macro SIS_CRDATA_RESP_STATS_EN.
- Defined:
  - Adds outputs rd_count[31:0] and wr_count[31:0]. They count accepted legal Avalon reads and writes (writes with byteenable = 0 included).
  - Both saturate at 32'hFFFF_FFFF, reset to 0, and clear with err_clr.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package sis_crdata_pkg holds:
  - word type (64-bit);
  - constant for bytes-per-word = 8 and its log2 = 3;
  - legal-address check function;
  - byte-merge function (old word, new word, byteenable → word).
- One natural sub-module: sis_crdata_rdpipe, a parameterised READ_LATENCY-deep valid+data shift pipeline with async clear.
- The memory array and decode stay in the top.

Test Plan:
- Preload word 5 = 64'h0123_4567_89AB_CDEF; Avalon read at BASE+0x28 → readdata = 64'h0123_4567_89AB_CDEF exactly 2 cycles later, err = 0.
- Avalon write 0x28, writedata 64'hFFFF_FFFF_FFFF_FFFF, byteenable 8'h0F; then read → 64'h0123_4567_FFFF_FFFF.
- Reads to words 0,1,2,3 on consecutive cycles (preloaded 10,11,12,13) → readdata 10,11,12,13 on consecutive cycles starting at cycle +2.
- Read at BASE+0x2C (misaligned) → readdata 0 and err = 1; err_clr pulse → err = 0; with macro defined, rd_count is unchanged.
- Read and write to word 7 in the same cycle (old 64'hA, new 64'hB, byteenable FF) → readdata 64'hA, err = 1, subsequent read → 64'hB.
- Issue a read, assert reset one cycle later → readdata = 0 and stays 0 after release; a pre_we and an Avalon write to word 3 in the same cycle → pre_rdata/readback equals pre_wdata.

Source files
------------

// File: rtl/sis_crdata_avmm_responder_pkg.sv
// Shared types and helpers for the SiS CR-data Avalon-MM responder.
// Word type, byte geometry, address legality and byte-merge.
package sis_crdata_pkg;

  typedef logic [63:0] word_t;

  localparam int BYTES_PER_WORD = 8;
  localparam int BYTE_SEL_W     = 3;

  function automatic logic addr_legal(
    input logic [63:0] off,
    input int unsigned aw
  );
    return (off[BYTE_SEL_W-1:0] == '0) &&
           ((off >> (aw + BYTE_SEL_W)) == 64'd0);
  endfunction

  function automatic word_t byte_merge(
    input word_t      old_w,
    input word_t      new_w,
    input logic [7:0] be
  );
    word_t r;
    r = old_w;
    for (int b = 0; b < BYTES_PER_WORD; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/sis_crdata_avmm_responder_if.sv
// Avalon-MM bundle between the HLS master and the CR-data responder.
// No waitrequest/readdatavalid: reads return at a fixed latency.
interface sis_crdata_avmm_responder_if;
  import sis_crdata_pkg::*;

  logic [63:0] address;
  logic [7:0]  byteenable;
  logic        read;
  logic        write;
  word_t       writedata;
  word_t       readdata;

  modport master (
    output address, byteenable, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output readdata
  );

endinterface

// File: rtl/sis_crdata_avmm_responder_rdpipe.sv
// Fixed-latency read return pipeline with async clear.
// Each stage only loads when its feeder is valid, so the last one holds.
module sis_crdata_rdpipe
  import sis_crdata_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  in_vld,
  input  word_t in_data,
  output logic  out_vld,
  output word_t out_data
);

  logic [LAT-1:0] vld;
  word_t          dat [LAT];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < LAT; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_vld;
      if (in_vld) dat[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign out_vld  = vld[LAT-1];
  assign out_data = dat[LAT-1];

endmodule

// File: rtl/sis_crdata_avmm_responder.sv
// Avalon-MM responder backing the SiS_Pr crdata tables, plus backdoor port.
// Optional rd/wr counters: define SIS_CRDATA_RESP_STATS_EN.
module sis_crdata_avmm_responder
  import sis_crdata_pkg::*;
#(
  parameter int          ADDR_W       = 8,
  parameter int          READ_LATENCY = 2,
  parameter logic [63:0] BASE_ADDR    = 64'h0
) (
  input  logic                  clock,
  input  logic                  reset,
  sis_crdata_avmm_responder_if.slave avmm_0_rw,
  input  logic                  pre_we,
  input  logic [ADDR_W-1:0]     pre_addr,
  input  word_t                 pre_wdata,
  output word_t                 pre_rdata,
  output logic                  err,
  input  logic                  err_clr
`ifdef SIS_CRDATA_RESP_STATS_EN
  ,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  word_t mem [DEPTH];

  logic [63:0]       off;
  logic [ADDR_W-1:0] word;
  logic              legal;
  logic              wr_ok;
  logic              av_wr;
  logic              err_set;
  word_t             rd_data;
  logic              rd_vld_unused;

  assign off   = avmm_0_rw.address - BASE_ADDR;
  assign word  = off[ADDR_W+BYTE_SEL_W-1:BYTE_SEL_W];
  assign legal = addr_legal(off, ADDR_W);

  assign wr_ok = avmm_0_rw.write & legal & (|avmm_0_rw.byteenable);
  // Backdoor owns the whole word when both target it.
  assign av_wr = wr_ok & ~(pre_we & (pre_addr == word));

  assign rd_data = (avmm_0_rw.read & legal) ? mem[word] : '0;

  assign err_set = ((avmm_0_rw.read | avmm_0_rw.write) & ~legal) |
                   (avmm_0_rw.read & avmm_0_rw.write);

  always_ff @(posedge clock) begin
    if (av_wr)
      mem[word] <= byte_merge(mem[word], avmm_0_rw.writedata,
                              avmm_0_rw.byteenable);
    if (pre_we)
      mem[pre_addr] <= pre_wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_rdata <= '0;
      err       <= 1'b0;
    end else begin
      pre_rdata <= mem[pre_addr];
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  sis_crdata_rdpipe #(
    .LAT (READ_LATENCY)
  ) u_rdpipe (
    .clock    (clock),
    .reset    (reset),
    .in_vld   (avmm_0_rw.read),
    .in_data  (rd_data),
    .out_vld  (rd_vld_unused),
    .out_data (avmm_0_rw.readdata)
  );

`ifdef SIS_CRDATA_RESP_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (err_clr) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (avmm_0_rw.read & legal & (rd_count != '1))
        rd_count <= rd_count + 32'd1;
      if (avmm_0_rw.write & legal & (wr_count != '1))
        wr_count <= wr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sis_crdata_avmm_responder.sv
// Directed table-driven bench for sis_crdata_avmm_responder.
// Table of single transactions plus hand sequences for multi-cycle cases.
module tb_sis_crdata_avmm_responder;
  import sis_crdata_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  word_t       pre_wdata = '0;
  word_t       pre_rdata;
  logic        err;
  logic        err_clr = 1'b0;
`ifdef SIS_CRDATA_RESP_STATS_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
  logic [31:0] rc_before;
`endif

  int total = 0;
  int bad   = 0;

  sis_crdata_avmm_responder_if bus ();

  sis_crdata_avmm_responder #(
    .ADDR_W       (8),
    .READ_LATENCY (2),
    .BASE_ADDR    (64'h0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .avmm_0_rw (bus.slave),
    .pre_we    (pre_we),
    .pre_addr  (pre_addr),
    .pre_wdata (pre_wdata),
    .pre_rdata (pre_rdata),
    .err       (err),
    .err_clr   (err_clr)
`ifdef SIS_CRDATA_RESP_STATS_EN
    ,
    .rd_count  (rd_count),
    .wr_count  (wr_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_bus();
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.byteenable = '0;
    bus.address = '0;
    bus.writedata = '0;
  endtask

  task automatic preload(input logic [7:0] a, input word_t d);
    pre_we = 1'b1;
    pre_addr = a;
    pre_wdata = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1, 0, 64'h28, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 0};
    vecs[1]  = '{0, 1, 64'h28, '1, 8'h0F, 64'h0, 0};
    vecs[2]  = '{1, 0, 64'h28, 64'h0, 8'h00, 64'h0123_4567_FFFF_FFFF, 0};
    vecs[3]  = '{0, 1, 64'h30, 64'h1234, 8'h00, 64'h0, 0};
    vecs[4]  = '{1, 0, 64'h30, 64'h0, 8'h00, 64'h66, 0};
    vecs[5]  = '{1, 0, 64'h2C, 64'h0, 8'h00, 64'h0, 1};
    vecs[6]  = '{0, 1, 64'h2C, 64'h99, 8'hFF, 64'h0, 1};
    vecs[7]  = '{1, 0, 64'h800, 64'h0, 8'h00, 64'h0, 1};
    vecs[8]  = '{0, 1, 64'h7F8, 64'h77, 8'hFF, 64'h0, 0};
    vecs[9]  = '{1, 0, 64'h7F8, 64'h0, 8'h00, 64'h77, 0};
    vecs[10] = '{0, 1, 64'h28, {16{4'hA}}, 8'hF0, 64'h0, 0};
    vecs[11] = '{1, 0, 64'h28, 64'h0, 8'h00, 64'hAAAA_AAAA_FFFF_FFFF, 0};

    idle_bus();
    #2;
    chk("rst_readdata", bus.readdata, 64'h0);
    chk("rst_pre_rdata", pre_rdata, 64'h0);
    chk("rst_err", {63'h0, err}, 64'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    preload(8'd5, 64'h0123_4567_89AB_CDEF);
    preload(8'd6, 64'h66);
    preload(8'd0, 64'd10);
    preload(8'd1, 64'd11);
    preload(8'd2, 64'd12);
    preload(8'd3, 64'd13);
    preload(8'd7, 64'hA);

    for (int i = 0; i < 12; i++) begin
      bus.read = vecs[i].rd;
      bus.write = vecs[i].wr;
      bus.address = vecs[i].addr;
      bus.writedata = vecs[i].wdata;
      bus.byteenable = vecs[i].be;
      tick();
      idle_bus();
      tick();
      if (vecs[i].rd)
        chk($sformatf("vec%0d_rd", i), bus.readdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {63'h0, err},
          {63'h0, vecs[i].exp_err});
      clr_err();
      chk($sformatf("vec%0d_clr", i), {63'h0, err}, 64'h0);
    end

    // Back-to-back reads, exact latency of two edges.
    for (int i = 0; i < 4; i++) begin
      bus.read = 1'b1;
      bus.address = 64'(i * 8);
      tick();
      if (i == 0)
        chk("b2b_lat", bus.readdata, 64'hAAAA_AAAA_FFFF_FFFF);
      else
        chk($sformatf("b2b_%0d", i - 1), bus.readdata, 64'(10 + i - 1));
    end
    idle_bus();
    tick();
    chk("b2b_3", bus.readdata, 64'd13);
    tick();
    chk("b2b_hold", bus.readdata, 64'd13);

`ifdef SIS_CRDATA_RESP_STATS_EN
    rc_before = rd_count;
    bus.read = 1'b1;
    bus.address = 64'h2C;
    tick();
    idle_bus();
    tick();
    chk("stat_rd_illegal", {32'h0, rd_count}, {32'h0, rc_before});
    clr_err();
    chk("stat_clr", {32'h0, rd_count}, 64'h0);
`endif

    // Read and write together on word 7.
    bus.read = 1'b1;
    bus.write = 1'b1;
    bus.address = 64'h38;
    bus.writedata = 64'hB;
    bus.byteenable = 8'hFF;
    tick();
    idle_bus();
    tick();
    chk("rw_old", bus.readdata, 64'hA);
    chk("rw_err", {63'h0, err}, 64'h1);
    clr_err();
    bus.read = 1'b1;
    bus.address = 64'h38;
    tick();
    idle_bus();
    tick();
    chk("rw_new", bus.readdata, 64'hB);

    // Set wins over clear.
    bus.read = 1'b1;
    bus.address = 64'hFFFF_FFFF_FFFF_FFF8;
    err_clr = 1'b1;
    tick();
    idle_bus();
    err_clr = 1'b0;
    chk("set_wins", {63'h0, err}, 64'h1);
    tick();
    chk("wrap_rd", bus.readdata, 64'h0);
    clr_err();

    bus.read = 1'b1;
    bus.address = 64'h8;
    tick();
    chk("pre_reset_data", bus.readdata, 64'h0);
    idle_bus();
    tick();
    chk("pre_reset_rd", bus.readdata, 64'd11);

    // Reset with a read in flight.
    bus.read = 1'b1;
    bus.address = 64'h10;
    tick();
    idle_bus();
    reset = 1'b1;
    #1;
    chk("mid_rst_rd", bus.readdata, 64'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst_%0d", i), bus.readdata, 64'h0);
    end
    chk("post_rst_err", {63'h0, err}, 64'h0);

    // Backdoor and Avalon write collide on word 3.
    pre_we = 1'b1;
    pre_addr = 8'd3;
    pre_wdata = 64'hC0DE;
    bus.write = 1'b1;
    bus.address = 64'h18;
    bus.writedata = 64'hDEAD;
    bus.byteenable = 8'hFF;
    tick();
    pre_we = 1'b0;
    idle_bus();
    tick();
    chk("pre_wins_peek", pre_rdata, 64'hC0DE);
    bus.read = 1'b1;
    bus.address = 64'h18;
    tick();
    idle_bus();
    tick();
    chk("pre_wins_rd", bus.readdata, 64'hC0DE);

    // Different words: both land.
    pre_we = 1'b1;
    pre_addr = 8'd4;
    pre_wdata = 64'h4444;
    bus.write = 1'b1;
    bus.address = 64'h10;
    bus.writedata = 64'h2222;
    bus.byteenable = 8'hFF;
    tick();
    pre_we = 1'b0;
    idle_bus();
    tick();
    chk("both_pre", pre_rdata, 64'h4444);
    bus.read = 1'b1;
    bus.address = 64'h10;
    tick();
    idle_bus();
    tick();
    chk("both_av", bus.readdata, 64'h2222);
    chk("end_err", {63'h0, err}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
